control_sequencer: RTL and testbench

Microcoded controller for the SAP-U datapath; sits directly upstream of the registers, ALU and RAM and drives all of their control strobes.
- Holds a 3-bit micro-step counter (T0..T4) and a halt latch.
- Decodes the instruction-register opcode, the step and the ALU flags into a 16-bit control word consumed by the top level.
- Terminates each instruction early at its last active step, so instructions have no dead cycles.

---
 rtl/sap_ctrl_pkg.sv | 53 +++++
 rtl/microcode_rom.sv | 101 ++++++++++
 rtl/sap_bus_checker.sv | 14 +
 rtl/control_sequencer.sv | 85 ++++++++
 tb/tb_control_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP-U control sequencer: opcodes, control-word bit
// positions, micro-step indices and the bus single-driver helper.
package sap_ctrl_pkg;

   localparam int STEP_W    = 3;
   localparam int LAST_STEP = 4;
   localparam int CTRL_W    = 16;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   localparam int CTRL_HLT = 0;
   localparam int CTRL_MI  = 1;
   localparam int CTRL_RI  = 2;
   localparam int CTRL_RO  = 3;
   localparam int CTRL_IO  = 4;
   localparam int CTRL_II  = 5;
   localparam int CTRL_AI  = 6;
   localparam int CTRL_AO  = 7;
   localparam int CTRL_EO  = 8;
   localparam int CTRL_SU  = 9;
   localparam int CTRL_BI  = 10;
   localparam int CTRL_OI  = 11;
   localparam int CTRL_CE  = 12;
   localparam int CTRL_CO  = 13;
   localparam int CTRL_J   = 14;
   localparam int CTRL_FI  = 15;

   localparam logic [STEP_W-1:0] T0 = 3'd0;
   localparam logic [STEP_W-1:0] T1 = 3'd1;
   localparam logic [STEP_W-1:0] T2 = 3'd2;
   localparam logic [STEP_W-1:0] T3 = 3'd3;
   localparam logic [STEP_W-1:0] T4 = 3'd4;

   // True when no more than one of the bus output enables is set.
   function automatic logic bus_single_driver(input logic [CTRL_W-1:0] w);
      logic [4:0] drv;
      drv = {w[CTRL_RO], w[CTRL_IO], w[CTRL_AO], w[CTRL_EO], w[CTRL_CO]};
      return ((drv & (drv - 5'd1)) == 5'd0);
   endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps opcode, micro-step and ALU flags to the raw
// control word plus a flag marking the last active step of the instruction.
module microcode_rom
   import sap_ctrl_pkg::*;
(
   input  logic [3:0]        opcode,
   input  logic [STEP_W-1:0] step,
   input  logic              flag_carry,
   input  logic              flag_zero,
   output logic [CTRL_W-1:0] ctrl_word,
   output logic              end_step
);

   // Fetch is shared; execute steps are decoded per opcode, undefined ones act as NOP.
   always_comb begin
      ctrl_word = 16'h0000;
      end_step  = 1'b0;
      case (step)
         T0: begin
            ctrl_word[CTRL_CO] = 1'b1;
            ctrl_word[CTRL_MI] = 1'b1;
         end
         T1: begin
            ctrl_word[CTRL_RO] = 1'b1;
            ctrl_word[CTRL_II] = 1'b1;
            ctrl_word[CTRL_CE] = 1'b1;
         end
         T2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl_word[CTRL_IO] = 1'b1;
                  ctrl_word[CTRL_MI] = 1'b1;
               end
               OP_LDI: begin
                  ctrl_word[CTRL_IO] = 1'b1;
                  ctrl_word[CTRL_AI] = 1'b1;
                  end_step           = 1'b1;
               end
               OP_JMP: begin
                  ctrl_word[CTRL_IO] = 1'b1;
                  ctrl_word[CTRL_J]  = 1'b1;
                  end_step           = 1'b1;
               end
               OP_JC: begin
                  ctrl_word[CTRL_IO] = flag_carry;
                  ctrl_word[CTRL_J]  = flag_carry;
                  end_step           = 1'b1;
               end
               OP_JZ: begin
                  ctrl_word[CTRL_IO] = flag_zero;
                  ctrl_word[CTRL_J]  = flag_zero;
                  end_step           = 1'b1;
               end
               OP_OUT: begin
                  ctrl_word[CTRL_AO] = 1'b1;
                  ctrl_word[CTRL_OI] = 1'b1;
                  end_step           = 1'b1;
               end
               OP_HLT: begin
                  ctrl_word[CTRL_HLT] = 1'b1;
                  end_step            = 1'b1;
               end
               default: end_step = 1'b1;
            endcase
         end
         T3: begin
            case (opcode)
               OP_LDA: begin
                  ctrl_word[CTRL_RO] = 1'b1;
                  ctrl_word[CTRL_AI] = 1'b1;
                  end_step           = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl_word[CTRL_RO] = 1'b1;
                  ctrl_word[CTRL_BI] = 1'b1;
               end
               OP_STA: begin
                  ctrl_word[CTRL_AO] = 1'b1;
                  ctrl_word[CTRL_RI] = 1'b1;
                  end_step           = 1'b1;
               end
               default: end_step = 1'b1;
            endcase
         end
         T4: begin
            case (opcode)
               OP_ADD, OP_SUB: begin
                  ctrl_word[CTRL_EO] = 1'b1;
                  ctrl_word[CTRL_AI] = 1'b1;
                  ctrl_word[CTRL_FI] = 1'b1;
                  ctrl_word[CTRL_SU] = (opcode == OP_SUB);
               end
               default: ctrl_word = 16'h0000;
            endcase
            end_step = 1'b1;
         end
         default: end_step = 1'b1;
      endcase
   end

endmodule

// File: rtl/sap_bus_checker.sv
// Property checker: the shared bus never has more than one driver enabled.
module sap_bus_checker
   import sap_ctrl_pkg::*;
(
   input logic              clk,
   input logic              reset,
   input logic [CTRL_W-1:0] ctrl
);

   a_bus_single_driver : assert property (@(posedge clk) disable iff (reset)
      bus_single_driver(ctrl))
      else $error("bus contention, ctrl=%h", ctrl);

endmodule

// File: rtl/control_sequencer.sv
// SAP-U control sequencer: micro-step counter, halt latch and run/halt gating
// around the microcode ROM.
module control_sequencer
   import sap_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        opcode,
   input  logic              flag_carry,
   input  logic              flag_zero,
   input  logic              run_enable,
   output logic [CTRL_W-1:0] ctrl,
   output logic [STEP_W-1:0] step,
   output logic              instr_done,
   output logic              halted
);

   localparam logic [STEP_W-1:0] LAST_STEP_V = 3'd4;
   localparam logic [STEP_W-1:0] STEP_ONE    = 3'd1;

   logic [STEP_W-1:0] step_q, step_d;
   logic              halted_q, halted_d;
   logic [CTRL_W-1:0] rom_ctrl_s;
   logic              rom_end_s;
   logic              last_s;

   microcode_rom u_rom (
      .opcode     (opcode),
      .step       (step_q),
      .flag_carry (flag_carry),
      .flag_zero  (flag_zero),
      .ctrl_word  (rom_ctrl_s),
      .end_step   (rom_end_s)
   );

   assign last_s = rom_end_s | (step_q == LAST_STEP_V);

   // Output gating: halt strobe dominates, a frozen sequencer drives nothing.
   always_comb begin
      ctrl       = 16'h0000;
      instr_done = 1'b0;
      if (halted_q) begin
         ctrl       = 16'h0001;
         instr_done = 1'b0;
      end else if (!run_enable) begin
         ctrl       = 16'h0000;
         instr_done = 1'b0;
      end else begin
         ctrl       = rom_ctrl_s;
         instr_done = last_s;
      end
   end

   // Next state: HLT parks at its own step, otherwise wrap on the end step.
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (!run_enable || halted_q) begin
         step_d   = step_q;
         halted_d = halted_q;
      end else if (rom_ctrl_s[CTRL_HLT]) begin
         step_d   = step_q;
         halted_d = 1'b1;
      end else if (last_s) begin
         step_d   = T0;
      end else begin
         step_d   = step_q + STEP_ONE;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed vectors push expectations,
// a negedge monitor pops and compares, and checks the bus single-driver rule.
module tb_control_sequencer;
   import sap_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  opcode = 4'h0;
   logic        flag_carry = 1'b0;
   logic        flag_zero = 1'b0;
   logic        run_enable = 1'b1;
   logic [15:0] ctrl;
   logic [2:0]  step;
   logic        instr_done;
   logic        halted;

   typedef struct {
      int          id;
      logic [15:0] ctrl;
      logic [2:0]  step;
      logic        done;
      logic        halted;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;
   logic mon_en = 1'b0;

   control_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .flag_carry (flag_carry),
      .flag_zero  (flag_zero),
      .run_enable (run_enable),
      .ctrl       (ctrl),
      .step       (step),
      .instr_done (instr_done),
      .halted     (halted)
   );

   sap_bus_checker u_chk (.clk(clk), .reset(reset), .ctrl(ctrl));

   always #5 clk = ~clk;

   // Apply inputs for one cycle, record what the outputs must be, advance.
   task automatic v(input logic r, input logic run, input logic [3:0] op,
                    input logic c, input logic z, input logic [15:0] ec,
                    input logic [2:0] es, input logic ed, input logic eh);
      exp_t e;
      reset = r; run_enable = run; opcode = op; flag_carry = c; flag_zero = z;
      e.id = vec_id; e.ctrl = ec; e.step = es; e.done = ed; e.halted = eh;
      exp_q.push_back(e);
      vec_id++;
      @(posedge clk); #1;
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         logic [4:0] drv;
         drv = {ctrl[3], ctrl[4], ctrl[7], ctrl[8], ctrl[13]};
         checks++;
         if ($countones(drv) > 1) begin
            errors++;
            $display("FAIL bus_driver ctrl=%h drivers=%b required at most one", ctrl, drv);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e.ctrl || step !== e.step || instr_done !== e.done || halted !== e.halted) begin
               errors++;
               $display("FAIL vec%0d got ctrl=%h step=%0d done=%b halted=%b required ctrl=%h step=%0d done=%b halted=%b",
                        e.id, ctrl, step, instr_done, halted, e.ctrl, e.step, e.done, e.halted);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      // reset state, run on and off
      v(1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b0, OP_ADD, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
      // ADD
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h0012, 3'd2, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h0408, 3'd3, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h8140, 3'd4, 1'b1, 1'b0);
      // SUB
      v(1'b0, 1'b1, OP_SUB, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_SUB, 1'b0, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_SUB, 1'b0, 1'b0, 16'h0012, 3'd2, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_SUB, 1'b0, 1'b0, 16'h0408, 3'd3, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_SUB, 1'b1, 1'b1, 16'h8340, 3'd4, 1'b1, 1'b0);
      // JZ not taken, flags ignored outside T2
      v(1'b0, 1'b1, OP_JZ,  1'b1, 1'b1, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_JZ,  1'b1, 1'b1, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_JZ,  1'b1, 1'b0, 16'h0000, 3'd2, 1'b1, 1'b0);
      // JZ taken
      v(1'b0, 1'b1, OP_JZ,  1'b0, 1'b1, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_JZ,  1'b0, 1'b1, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_JZ,  1'b0, 1'b1, 16'h4010, 3'd2, 1'b1, 1'b0);
      // JC taken and not taken
      v(1'b0, 1'b1, OP_JC,  1'b1, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_JC,  1'b1, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_JC,  1'b1, 1'b0, 16'h4010, 3'd2, 1'b1, 1'b0);
      v(1'b0, 1'b1, OP_JC,  1'b0, 1'b1, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_JC,  1'b0, 1'b1, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_JC,  1'b0, 1'b1, 16'h0000, 3'd2, 1'b1, 1'b0);
      // LDA with reset at T3
      v(1'b0, 1'b1, OP_LDA, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_LDA, 1'b0, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_LDA, 1'b0, 1'b0, 16'h0012, 3'd2, 1'b0, 1'b0);
      v(1'b1, 1'b1, OP_LDA, 1'b0, 1'b0, 16'h0048, 3'd3, 1'b1, 1'b0);
      // ADD frozen at T3 for four cycles
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h0012, 3'd2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         v(1'b0, 1'b0, OP_ADD, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h0408, 3'd3, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 16'h8140, 3'd4, 1'b1, 1'b0);
      // STA, OUT, undefined, LDI
      v(1'b0, 1'b1, OP_STA, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_STA, 1'b0, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_STA, 1'b0, 1'b0, 16'h0012, 3'd2, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_STA, 1'b0, 1'b0, 16'h0084, 3'd3, 1'b1, 1'b0);
      v(1'b0, 1'b1, OP_OUT, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_OUT, 1'b0, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_OUT, 1'b0, 1'b0, 16'h0880, 3'd2, 1'b1, 1'b0);
      v(1'b0, 1'b1, 4'hA,   1'b1, 1'b1, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, 4'hA,   1'b1, 1'b1, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, 4'hA,   1'b1, 1'b1, 16'h0000, 3'd2, 1'b1, 1'b0);
      v(1'b0, 1'b1, OP_LDI, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_LDI, 1'b0, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_LDI, 1'b0, 1'b0, 16'h0050, 3'd2, 1'b1, 1'b0);
      // HLT, stay halted regardless of run_enable, then reset
      v(1'b0, 1'b1, OP_HLT, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_HLT, 1'b0, 1'b0, 16'h1028, 3'd1, 1'b0, 1'b0);
      v(1'b0, 1'b1, OP_HLT, 1'b0, 1'b0, 16'h0001, 3'd2, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++)
         v(1'b0, i[0], OP_HLT, 1'b0, 1'b0, 16'h0001, 3'd2, 1'b0, 1'b1);
      v(1'b1, 1'b1, OP_HLT, 1'b0, 1'b0, 16'h0001, 3'd2, 1'b0, 1'b1);
      v(1'b0, 1'b1, OP_NOP, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0, 1'b0);
      // random traffic without HLT; monitor checks the bus rule each cycle
      for (int i = 0; i < 1000; i++) begin
         reset      = ($urandom_range(0, 99) == 0);
         run_enable = ($urandom_range(0, 7) != 0);
         opcode     = 4'($urandom_range(0, 14));
         flag_carry = 1'($urandom_range(0, 1));
         flag_zero  = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
